// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling, byte strobes with fixed-width valid.
// rx_data is updated one cycle before rx_valid rises; a bad stop bit raises frame_err and waits out the break.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int VALID_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int VW = $clog2(VALID_CYCLES + 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic [1:0]    sync_q;
  logic          rxd_s;
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          ok_q, ok_d;
  logic          bad_q, bad_d;
  logic          frame_err_q;
  logic [VW-1:0] vcnt_q;

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
      frame_err_q <= bad_q;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        // A start bit that is high again at mid-bit is treated as line noise.
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            ok_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad_d   = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        baud_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Loaded one cycle after the accept so the bridge sees a full cycle of data setup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vcnt_q <= '0;
    end else if (ok_q) begin
      vcnt_q <= VW'(VALID_CYCLES);
    end else if (vcnt_q != '0) begin
      vcnt_q <= vcnt_q - VW'(1);
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = (vcnt_q != '0);
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks/bit, 4-cycle valid strobe.
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int VC  = 4;
  localparam int CLK_T = 100;
  localparam int BIT   = CPB * CLK_T;
  localparam int BIT_FAST = 1552;
  localparam int BIT_SLOW = 1648;

  logic       clk;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .VALID_CYCLES(VC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #(CLK_T / 2) clk = ~clk;

  // Observer: records strobed bytes, strobe widths, data-to-strobe setup and frame_err cycles.
  logic [7:0] rx_q[$];
  int         width_q[$];
  int         setup_q[$];
  int         ferr_cyc = 0;
  int         cyc = 0;
  int         last_chg = 0;
  int         hi = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_data !== prev_data) last_chg = cyc;
    if (rx_valid && !prev_valid) begin
      rx_q.push_back(rx_data);
      setup_q.push_back(cyc - last_chg);
      hi = 0;
    end
    if (rx_valid) hi = hi + 1;
    if (!rx_valid && prev_valid) width_q.push_back(hi);
    if (frame_err) ferr_cyc = ferr_cyc + 1;
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total = total + 1;
    if (obs !== exp_v) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    width_q.delete();
    setup_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int bit_t);
    rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_t);
    end
    rxd = stop_v;
    #(bit_t);
  endtask

  function automatic logic [31:0] q_at(input int i);
    if (i < rx_q.size()) return {24'h0, rx_q[i]};
    return 32'h100;
  endfunction

  logic [7:0] stream_v[9] = '{8'h77, 8'h00, 8'h10, 8'h00, 8'h10, 8'h34, 8'h12, 8'hEF, 8'hBE};
  logic [7:0] skew_v[4]   = '{8'h55, 8'hAA, 8'h55, 8'hAA};
  int         skew_t[4]   = '{BIT_SLOW, BIT_SLOW, BIT_FAST, BIT_FAST};

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'h0, rx_data}, 32'h00);
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single good byte
    clear_obs();
    send_byte(8'h77, 1'b1, BIT);
    repeat (40) @(negedge clk);
    chk("one_cnt", rx_q.size(), 1);
    chk("one_data", q_at(0), 32'h77);
    chk("one_width", (width_q.size() > 0) ? width_q[0] : -1, VC);
    chk("one_setup", (setup_q.size() > 0) ? setup_q[0] : -1, 1);
    chk("one_ferr", ferr_cyc, 0);

    // Back-to-back stream, no idle between frames
    clear_obs();
    for (int i = 0; i < 9; i++) send_byte(stream_v[i], 1'b1, BIT);
    repeat (40) @(negedge clk);
    chk("strm_cnt", rx_q.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("strm_b%0d", i), q_at(i), {24'h0, stream_v[i]});
    chk("strm_ferr", ferr_cyc, 0);

    // Start-bit glitch of 5 cycles
    clear_obs();
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    chk("glt_busy_hi", {31'h0, busy}, 32'h1);
    @(negedge clk);
    rxd = 1'b1;
    for (int k = 0; k < 9 && busy; k++) @(negedge clk);
    chk("glt_busy_lo", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk("glt_novalid", rx_q.size(), 0);
    chk("glt_noferr", ferr_cyc, 0);

    // Bad stop bit followed by a 40-bit break, then a good byte
    clear_obs();
    send_byte(8'hA5, 1'b0, BIT);
    #(40 * BIT);
    rxd = 1'b1;
    #(2 * BIT);
    chk("fe_pulse", ferr_cyc, 1);
    chk("fe_hold", {24'h0, rx_data}, 32'hBE);
    chk("fe_novalid", rx_q.size(), 0);
    send_byte(8'h3C, 1'b1, BIT);
    repeat (40) @(negedge clk);
    chk("fe_rec_cnt", rx_q.size(), 1);
    chk("fe_rec_data", q_at(0), 32'h3C);
    chk("fe_no_more", ferr_cyc, 1);

    // Reset asserted during data bit 4 of 0xFF
    clear_obs();
    @(negedge clk);
    rxd = 1'b0;
    #(BIT);
    rxd = 1'b1;
    #(4 * BIT + BIT / 2);
    reset = 1'b1;
    #10;
    chk("mr_data", {24'h0, rx_data}, 32'h00);
    chk("mr_valid", {31'h0, rx_valid}, 32'h0);
    chk("mr_ferr", {31'h0, frame_err}, 32'h0);
    chk("mr_busy", {31'h0, busy}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #(6 * BIT);
    send_byte(8'h72, 1'b1, BIT);
    repeat (40) @(negedge clk);
    chk("mr_cnt", rx_q.size(), 1);
    chk("mr_data2", q_at(0), 32'h72);

    // Line rate +/-3% off nominal
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      send_byte(skew_v[i], 1'b1, skew_t[i]);
      #(2 * BIT);
    end
    repeat (20) @(negedge clk);
    chk("skew_cnt", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("skew_b%0d", i), q_at(i), {24'h0, skew_v[i]});
    chk("skew_ferr", ferr_cyc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
